// File: rtl/lvds_frame_packer.sv
// Packs ADC sample groups into byte-wide LVDS TX lanes as fixed-length frames:
// sync beat, frame-counter beat, BEATS payload beats, then GAP_BEATS idle beats.
module lvds_frame_packer #(
  parameter int unsigned SAMPLE_W          = 14,
  parameter int unsigned LANES             = 4,
  parameter int unsigned SAMPLES_PER_FRAME = 256,
  parameter int unsigned GAP_BEATS         = 2,
  parameter logic [7:0]  SYNC_BYTE         = 8'hA5,
  parameter logic [7:0]  IDLE_BYTE         = 8'h00
) (
  input  logic                            lvds_parallel_clk,
  input  logic                            lvds_rst,
  input  logic                            enable,
  input  logic [(LANES/2)*SAMPLE_W-1:0]   s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic [LANES*8-1:0]              lvds_tx_data,
  output logic                            frame_start,
  output logic [15:0]                     frame_cnt,
  output logic                            underrun,
  output logic                            underrun_sticky
);

  localparam int unsigned SLOTS   = LANES / 2;
  localparam int unsigned BEATS   = SAMPLES_PER_FRAME / SLOTS;
  localparam int unsigned CNT_MAX = (BEATS > GAP_BEATS) ? BEATS : GAP_BEATS;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_BEATS > 0) ? GAP_BEATS - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_CNT,
    ST_PAYLOAD,
    ST_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LANES*8-1:0] tx_q, tx_d;
  logic               frame_start_q, frame_start_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               underrun_q, underrun_d;
  logic               sticky_q, sticky_d;
  logic [15:0]        slot_word;

  always_ff @(posedge lvds_parallel_clk) begin
    if (lvds_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q is shared: payload beat index in PAYLOAD, gap beat index in GAP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: if (enable) state_d = ST_HDR;
      ST_HDR:  state_d = ST_CNT;
      ST_CNT: begin
        state_d = ST_PAYLOAD;
        cnt_d   = '0;
      end
      ST_PAYLOAD: begin
        if (cnt_q == BEAT_LAST) begin
          cnt_d = '0;
          if (GAP_BEATS > 0) state_d = ST_GAP;
          else               state_d = enable ? ST_HDR : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = enable ? ST_HDR : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_d          = {LANES{IDLE_BYTE}};
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    underrun_d    = 1'b0;
    slot_word     = '0;
    unique case (state_q)
      ST_HDR: begin
        tx_d          = {LANES{SYNC_BYTE}};
        frame_start_d = 1'b1;
      end
      ST_CNT: begin
        tx_d       = {LANES{SYNC_BYTE}};
        tx_d[7:0]  = frame_cnt_q[15:8];
        tx_d[15:8] = frame_cnt_q[7:0];
      end
      ST_PAYLOAD: begin
        underrun_d = ~s_valid;
        for (int unsigned j = 0; j < SLOTS; j++) begin
          slot_word = s_valid ? {{(16-SAMPLE_W){1'b0}}, s_data[j*SAMPLE_W +: SAMPLE_W]}
                              : 16'hFFFF;
          tx_d[(2*j)*8 +: 8]   = slot_word[15:8];
          tx_d[(2*j+1)*8 +: 8] = slot_word[7:0];
        end
        if (cnt_q == BEAT_LAST) frame_cnt_d = frame_cnt_q + 16'd1;
      end
      default: ;
    endcase
    sticky_d = sticky_q | underrun_d;
  end

  always_ff @(posedge lvds_parallel_clk) begin
    if (lvds_rst) begin
      tx_q          <= {LANES{IDLE_BYTE}};
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      underrun_q    <= 1'b0;
      sticky_q      <= 1'b0;
    end else begin
      tx_q          <= tx_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
      underrun_q    <= underrun_d;
      sticky_q      <= sticky_d;
    end
  end

  assign s_ready         = (state_q == ST_PAYLOAD);
  assign lvds_tx_data    = tx_q;
  assign frame_start     = frame_start_q;
  assign frame_cnt       = frame_cnt_q;
  assign underrun        = underrun_q;
  assign underrun_sticky = sticky_q;

endmodule
